// File: rtl/lap_stopwatch_pkg.sv
// Shared field widths, limits and state encoding for the stopwatch core.
// Also provides the packing helper that builds one lap record.
package stopwatch_defs;

    localparam int HOUR_W    = 7;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;
    localparam int CS_W      = 7;
    localparam int LAP_WIDTH = HOUR_W + MIN_W + SEC_W + CS_W;

    localparam logic [CS_W-1:0]  CS_MAX = 7'd99;
    localparam logic [MIN_W-1:0] SM_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    function automatic logic [LAP_WIDTH-1:0] pack_time(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m,
        input logic [SEC_W-1:0]  s,
        input logic [CS_W-1:0]   c
    );
        return {h, m, s, c};
    endfunction

endpackage

// File: rtl/sw_time_counter.sv
// Mixed-radix h:m:s:cs counter. A clear that coincides with an increment
// restarts the count at one centisecond, so no tick is lost.
module sw_time_counter
    import stopwatch_defs::*;
#(
    parameter int HOUR_LIMIT = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second,
    output logic [CS_W-1:0]   m_sec
);

    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_LIMIT - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
            m_sec  <= '0;
        end else if (clr) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
            m_sec  <= inc ? CS_W'(1) : '0;
        end else if (inc) begin
            if (m_sec == CS_MAX) begin
                m_sec <= '0;
                if (second == SM_MAX) begin
                    second <= '0;
                    if (minute == SM_MAX) begin
                        minute <= '0;
                        hour   <= (hour == HOUR_MAX) ? '0 : hour + 1'b1;
                    end else begin
                        minute <= minute + 1'b1;
                    end
                end else begin
                    second <= second + 1'b1;
                end
            end else begin
                m_sec <= m_sec + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core: run/pause/zero FSM, tick prescaler, total and lap counters,
// and a lap record FIFO read back through a strobe port.
module lap_stopwatch
    import stopwatch_defs::*;
#(
    parameter  int CLOCK_HZ   = 50_000_000,
    parameter  int TICK_HZ    = 100,
    parameter  int HOUR_LIMIT = 100,
    parameter  int LAP_DEPTH  = 8,
    localparam int AW         = $clog2(LAP_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_pause,
    input  logic                 zero,
    input  logic                 lap,
    input  logic                 clear,
    input  logic                 split_mode,
    input  logic                 lap_rd_en,
    output logic [HOUR_W-1:0]    hour,
    output logic [MIN_W-1:0]     minute,
    output logic [SEC_W-1:0]     second,
    output logic [CS_W-1:0]      m_sec,
    output logic                 running,
    output logic                 lap_rd_valid,
    output logic [LAP_WIDTH-1:0] lap_rd_data,
    output logic [AW:0]          lap_count,
    output logic                 lap_full,
    output logic                 lap_empty,
    output logic                 lap_overflow,
    output logic [1:0]           state_dbg
);

    localparam int DIV = CLOCK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_t     state;
    logic [PW-1:0] pre;
    logic          tick;

    assign state_dbg = state;
    assign tick      = (state == RUNNING) && (pre == PW'(DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (zero) begin
            pre <= '0;
        end else if (state == RUNNING) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // start_pause takes precedence over zero for the state transition;
    // zero still clears the counters in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pause) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (start_pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (start_pause) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end else if (zero) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Read port: lap_rd_en is a request with no ready; it is honoured when the
    // FIFO is non-empty and clear is low, answered by a one-cycle lap_rd_valid
    // on the next cycle. lap_rd_data holds between reads.
    logic [LAP_WIDTH-1:0] mem [LAP_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 lap_ok;
    logic                 do_rd;
    logic                 do_wr;
    logic                 drop;
    logic [LAP_WIDTH-1:0] lap_word;

    logic [HOUR_W-1:0] lap_hour;
    logic [MIN_W-1:0]  lap_minute;
    logic [SEC_W-1:0]  lap_second;
    logic [CS_W-1:0]   lap_m_sec;

    assign lap_count = wr_ptr - rd_ptr;
    assign lap_full  = (lap_count == (AW + 1)'(LAP_DEPTH));
    assign lap_empty = (lap_count == '0);

    assign lap_ok = lap & ~zero & ~clear;
    assign do_rd  = lap_rd_en & ~clear & ~lap_empty;
    assign do_wr  = lap_ok & (~lap_full | do_rd);
    assign drop   = lap_ok & lap_full & ~do_rd;

    assign lap_word = split_mode ? pack_time(hour, minute, second, m_sec)
                                 : pack_time(lap_hour, lap_minute, lap_second, lap_m_sec);

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= lap_word;
        end
    end

    // When full, a simultaneous read and write hit the same slot; the read
    // sees the old record because both use the pre-edge memory contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_overflow <= 1'b0;
            lap_rd_valid <= 1'b0;
            lap_rd_data  <= '0;
        end else begin
            lap_rd_valid <= do_rd;
            if (do_rd) begin
                lap_rd_data <= mem[rd_ptr[AW-1:0]];
            end
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                lap_overflow <= 1'b0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                if (drop)  lap_overflow <= 1'b1;
            end
        end
    end

    sw_time_counter #(.HOUR_LIMIT(HOUR_LIMIT)) u_total (
        .clock  (clock),
        .reset  (reset),
        .inc    (tick & ~zero),
        .clr    (zero),
        .hour   (hour),
        .minute (minute),
        .second (second),
        .m_sec  (m_sec)
    );

    sw_time_counter #(.HOUR_LIMIT(HOUR_LIMIT)) u_lap (
        .clock  (clock),
        .reset  (reset),
        .inc    (tick & ~zero),
        .clr    (zero | do_wr),
        .hour   (lap_hour),
        .minute (lap_minute),
        .second (lap_second),
        .m_sec  (lap_m_sec)
    );

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: centisecond-integer reference model, lap-record
// scoreboard queue, directed scenarios followed by random command pulses.
module tb_lap_stopwatch;

    localparam int CLK_HZ  = 10;
    localparam int TK_HZ   = 1;
    localparam int HL      = 2;
    localparam int DEPTH   = 4;
    localparam int DIV     = CLK_HZ / TK_HZ;
    localparam int HOUR_CS = 360000;
    localparam int MOD     = HL * HOUR_CS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic start_pause = 0, zero = 0, lap = 0, clear = 0, split_mode = 0, lap_rd_en = 0;
    logic [6:0]  hour;
    logic [5:0]  minute, second;
    logic [6:0]  m_sec;
    logic        running, lap_rd_valid, lap_full, lap_empty, lap_overflow;
    logic [25:0] lap_rd_data;
    logic [2:0]  lap_count;
    logic [1:0]  state_dbg;

    logic        f_start = 0;
    logic [6:0]  f_hour;
    logic [5:0]  f_minute, f_second;
    logic [6:0]  f_m_sec;
    logic        f_running, f_rd_valid, f_full, f_empty, f_overflow;
    logic [25:0] f_rd_data;
    logic [1:0]  f_count;
    logic [1:0]  f_state_dbg;

    lap_stopwatch #(.CLOCK_HZ(CLK_HZ), .TICK_HZ(TK_HZ), .HOUR_LIMIT(HL), .LAP_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start_pause(start_pause), .zero(zero), .lap(lap),
        .clear(clear), .split_mode(split_mode), .lap_rd_en(lap_rd_en),
        .hour(hour), .minute(minute), .second(second), .m_sec(m_sec), .running(running),
        .lap_rd_valid(lap_rd_valid), .lap_rd_data(lap_rd_data), .lap_count(lap_count),
        .lap_full(lap_full), .lap_empty(lap_empty), .lap_overflow(lap_overflow),
        .state_dbg(state_dbg)
    );

    // One tick per clock, to reach the minute carry in a short run.
    lap_stopwatch #(.CLOCK_HZ(1), .TICK_HZ(1), .HOUR_LIMIT(1), .LAP_DEPTH(2)) fast (
        .clock(clock), .reset(reset), .start_pause(f_start), .zero(1'b0), .lap(1'b0),
        .clear(1'b0), .split_mode(1'b0), .lap_rd_en(1'b0),
        .hour(f_hour), .minute(f_minute), .second(f_second), .m_sec(f_m_sec),
        .running(f_running), .lap_rd_valid(f_rd_valid), .lap_rd_data(f_rd_data),
        .lap_count(f_count), .lap_full(f_full), .lap_empty(f_empty),
        .lap_overflow(f_overflow), .state_dbg(f_state_dbg)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] pack_cs(input int t);
        int h, m, s, c;
        h = t / HOUR_CS;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return 26'((((h * 64) + m) * 64 + s) * 128 + c);
    endfunction

    // Reference model: state 0=idle 1=run 2=paused, times in centiseconds.
    int          m_state = 0, m_pre = 0, m_total = 0, m_lap = 0;
    logic        m_ovf = 0, m_rd_exp = 0;
    logic [25:0] m_last = '0;
    logic [25:0] fifo_q[$];
    logic [25:0] exp_q[$];
    bit          tick_m, lap_ok, rd_ok, push;
    logic [25:0] word;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_pre = 0; m_total = 0; m_lap = 0;
            m_ovf = 0; m_rd_exp = 0; m_last = '0;
            fifo_q.delete();
            exp_q.delete();
        end else begin
            tick_m = 0;
            if (m_state == 1 && !zero) begin
                m_pre++;
                if (m_pre == DIV) begin
                    m_pre  = 0;
                    tick_m = 1;
                end
            end
            if (zero) m_pre = 0;
            lap_ok = lap && !zero && !clear;
            rd_ok  = lap_rd_en && !clear && (fifo_q.size() > 0);
            word   = split_mode ? pack_cs(m_total) : pack_cs(m_lap);
            push   = lap_ok && ((fifo_q.size() < DEPTH) || rd_ok);
            if (lap_ok && !push) m_ovf = 1;
            if (clear) begin
                fifo_q.delete();
                m_ovf = 0;
            end
            m_rd_exp = rd_ok;
            if (rd_ok) begin
                m_last = fifo_q.pop_front();
                exp_q.push_back(m_last);
            end
            if (push) fifo_q.push_back(word);
            if (zero) begin
                m_total = 0;
                m_lap   = 0;
            end else begin
                if (tick_m) m_total = (m_total + 1) % MOD;
                if (push) m_lap = tick_m ? 1 : 0;
                else if (tick_m) m_lap = (m_lap + 1) % MOD;
            end
            if (start_pause) m_state = (m_state == 1) ? 2 : 1;
            else if (zero && m_state == 2) m_state = 0;
        end
    end

    // Monitor: compares registered outputs against the model between edges.
    logic [25:0] exp_word;
    always @(negedge clock) begin
        check("hour",   hour,   m_total / HOUR_CS);
        check("minute", minute, (m_total / 6000) % 60);
        check("second", second, (m_total / 100) % 60);
        check("m_sec",  m_sec,  m_total % 100);
        check("running",      running,      m_state == 1);
        check("lap_count",    lap_count,    fifo_q.size());
        check("lap_full",     lap_full,     fifo_q.size() == DEPTH);
        check("lap_empty",    lap_empty,    fifo_q.size() == 0);
        check("lap_overflow", lap_overflow, m_ovf);
        check("lap_rd_valid", lap_rd_valid, m_rd_exp);
        if (lap_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                exp_word = exp_q.pop_front();
                check("rd_data", lap_rd_data, exp_word);
            end
        end else begin
            if (m_rd_exp && exp_q.size() > 0) exp_word = exp_q.pop_front();
            check("rd_hold", lap_rd_data, m_last);
        end
    end

    task automatic drive(input bit sp, input bit zr, input bit lp, input bit cl, input bit rd);
        start_pause = sp; zero = zr; lap = lp; clear = cl; lap_rd_en = rd;
        @(negedge clock);
        start_pause = 0; zero = 0; lap = 0; clear = 0; lap_rd_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1;
        repeat (3) @(negedge clock);
        check("rst_empty", lap_empty, 1);
        check("rst_m_sec", m_sec, 0);
        reset = 0;

        // 100 ticks of 10 clocks each.
        drive(1, 0, 0, 0, 0);
        idle(1000);
        check("run_second", second, 1);
        check("run_m_sec",  m_sec, 0);
        check("run_running", running, 1);

        // 35 ticks, pause 50 clocks, resume for 5 ticks.
        drive(0, 1, 0, 0, 0);
        idle(350);
        check("pre_pause_m_sec", m_sec, 35);
        drive(1, 0, 0, 0, 0);
        idle(50);
        check("paused_m_sec", m_sec, 35);
        check("paused_running", running, 0);
        drive(1, 0, 0, 0, 0);
        idle(49);
        check("resume_m_sec", m_sec, 40);

        // Delta laps at ticks 10, 25, 30.
        split_mode = 0;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check("zero_idle_m_sec", m_sec, 0);
        drive(1, 0, 0, 0, 0);
        idle(100);
        drive(0, 0, 1, 0, 0);
        idle(149);
        drive(0, 0, 1, 0, 0);
        idle(49);
        drive(0, 0, 1, 0, 0);
        check("laps_count", lap_count, 3);
        drive(0, 0, 0, 0, 1);
        check("rd1_valid", lap_rd_valid, 1);
        check("rd1_data", lap_rd_data, 10);
        drive(0, 0, 0, 0, 1);
        check("rd2_data", lap_rd_data, 15);
        drive(0, 0, 0, 0, 1);
        check("rd3_data", lap_rd_data, 5);
        idle(1);
        check("rd_strobe_one_cycle", lap_rd_valid, 0);
        check("rd_data_hold", lap_rd_data, 5);
        drive(0, 0, 0, 0, 1);
        check("rd_empty_no_strobe", lap_rd_valid, 0);

        // Overflow, then simultaneous lap+read when full, then clear.
        repeat (5) drive(0, 0, 1, 0, 0);
        check("ovf_full", lap_full, 1);
        check("ovf_count", lap_count, 4);
        check("ovf_flag", lap_overflow, 1);
        drive(0, 0, 1, 0, 1);
        check("full_rw_count", lap_count, 4);
        check("full_rw_valid", lap_rd_valid, 1);
        drive(0, 0, 0, 1, 0);
        check("clear_count", lap_count, 0);
        check("clear_empty", lap_empty, 1);
        check("clear_ovf", lap_overflow, 0);

        // lap+zero and lap+clear collisions.
        drive(0, 1, 1, 0, 0);
        check("lapzero_count", lap_count, 0);
        check("lapzero_m_sec", m_sec, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        check("lapclear_empty", lap_empty, 1);

        for (int i = 0; i < 2000; i++) begin
            split_mode = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 6);
        end

        // Async reset while running with a read in flight.
        if (m_state != 1) drive(1, 0, 0, 0, 0);
        idle(15);
        drive(0, 0, 1, 0, 0);
        lap_rd_en = 1;
        @(posedge clock);
        #2 reset = 1;
        lap_rd_en = 0;
        #1;
        check("arst_m_sec", m_sec, 0);
        check("arst_second", second, 0);
        check("arst_running", running, 0);
        check("arst_count", lap_count, 0);
        check("arst_empty", lap_empty, 1);
        check("arst_valid", lap_rd_valid, 0);
        check("arst_data", lap_rd_data, 0);
        @(negedge clock);
        reset = 0;

        // Minute carry on the one-tick-per-clock instance.
        f_start = 1;
        @(negedge clock);
        f_start = 0;
        idle(5999);
        check("fast_second", f_second, 59);
        check("fast_m_sec", f_m_sec, 99);
        check("fast_minute0", f_minute, 0);
        idle(1);
        check("fast_minute1", f_minute, 1);
        check("fast_second0", f_second, 0);
        check("fast_m_sec0", f_m_sec, 0);
        check("fast_running", f_running, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised stopwatch core with lap memory. It counts hours, minutes, seconds and centiseconds from the system clock and runs a run/pause/zero state machine driven by single-cycle command pulses. It captures lap records into an on-chip FIFO of configurable depth, storing either absolute split times or per-lap deltas, and returns them through a read port. It sits between the debounced key logic and the bin2bcd/bcd2seg display path, which it feeds unchanged.

## Interface
- CLOCK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 100, count resolution; one tick = one centisecond count
- HOUR_LIMIT, 100, hours wrap from HOUR_LIMIT-1 to 0 (legal range 1..100)
- LAP_DEPTH, 8, lap FIFO entries (power of two, 2..64)
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start_pause  in  1  pulse; toggles run/pause
- zero  in  1  pulse; zeroes both time counters
- lap  in  1  pulse; capture one lap record
- clear  in  1  pulse; empties lap FIFO, clears overflow
- split_mode  in  1  1 = store absolute time, 0 = store lap delta; sampled on lap
- lap_rd_en  in  1  pulse; pop one record
- hour  out  7  total time hours
- minute, second  out  6 each  total time fields
- m_sec  out  7  centiseconds 0..99
- running  out  1  high in RUNNING
- lap_rd_valid  out  1  one-cycle strobe, lap_rd_data valid
- lap_rd_data  out  26  {hour[6:0], minute[5:0], second[5:0], m_sec[6:0]}
- lap_count  out  log2(LAP_DEPTH)+1  entries held
- lap_full, lap_empty  out  1 each  FIFO status
- lap_overflow  out  1  sticky; a lap was dropped because the FIFO was full

## Operation
- States: IDLE (zeroed, stopped), RUNNING, PAUSED. The reset state is IDLE.
- start_pause transitions: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
- zero transitions: PAUSED->IDLE, RUNNING->RUNNING with counters zeroed, IDLE->IDLE.
- Prescaler counts 0..CLOCK_HZ/TICK_HZ-1 only in RUNNING and holds in PAUSED.
  - zero or reset clears it.
  - The terminal count produces a one-cycle tick.
- Two mixed-radix counters: total and lap.
  - Each tick increments both by one centisecond.
  - Carry chain: cs 99->0, s 59->0, min 59->0, h HOUR_LIMIT-1->0.
  - No saturation; the wrap is silent.
- lap, when accepted:
  - Pushes the total time if split_mode=1, otherwise the lap counter.
  - The lap counter then restarts at 0. If a tick lands in the same cycle, the lap counter becomes 00:00:00:01.
  - A lap while PAUSED or IDLE is accepted and captures the held value.
- lap while full: the record is dropped, lap_overflow is set, and the lap counter is not restarted.
- Priority within one cycle:
  - zero beats lap (lap ignored).
  - clear beats lap and lap_rd_en (both ignored).
  - lap and lap_rd_en together are both served, even when full, in which case count is unchanged and there is no overflow.
- lap_rd_en while empty is ignored: no strobe, no state change.
- start_pause together with zero: both take effect. Counters are zeroed and the state follows the start_pause transition from the current state.

## Timing
- Reset values:
  - hour/minute/second/m_sec = 0, lap_rd_data = 0, lap_count = 0.
  - running, lap_full, lap_rd_valid, lap_overflow = 0.
  - lap_empty = 1.
- Time outputs are registered and update the cycle after tick.
- A command pulse at edge n affects state, running and counters at edge n.
- A lap push at edge n is visible in lap_count/full/empty after edge n.
- Read latency is 1: lap_rd_en at edge n gives lap_rd_valid high for one cycle after edge n with data in FIFO order. lap_rd_data holds until the next read.
- Reset asserted mid-count or mid-read clears everything immediately; in-flight strobes are lost.

## Structure
- Shared package stopwatch_defs:
  - Field widths (7/6/6/7).
  - LAP_WIDTH = 26.
  - State encodings IDLE/RUNNING/PAUSED.
  - Limits CS_MAX = 99, SM_MAX = 59.
- Sub-module sw_time_counter: a mixed-radix cascade with inc, clr and HOUR_LIMIT parameter. It is instantiated twice (total, lap).
- The FIFO is inline: register array, pointers one bit wider than the index.

## Test plan
- CLOCK_HZ=10, TICK_HZ=1, start_pause then 1000 clocks -> m_sec=100 impossible, so hour/min/sec/cs = 0:00:01:00. running=1.
- Pause after 35 ticks, wait 50 clocks, resume, 5 ticks -> 0:00:00:40. No count during pause.
- Preload via ticks to HOUR_LIMIT=2 boundary 1:59:59:99, one tick -> 0:00:00:00.
- split_mode=0, laps at ticks 10, 25, 30, then read 3 times -> data cs 10, 15, 5. lap_rd_valid is one cycle each, 1-cycle latency. Reading again with the FIFO empty -> no strobe.
- LAP_DEPTH=2, 3 laps -> lap_full=1, lap_count=2, lap_overflow=1. clear -> count 0, empty=1, overflow=0.
- lap+zero same cycle -> no push, counters 0. lap+clear same cycle -> FIFO empty. Async reset while RUNNING -> all outputs at reset values before the next edge.
